lut_neuron_pipe: RTL and testbench
==================================

LUT_NEURON_PIPE -- requirements
Module: lut_neuron_pipe

Interface
REQ-001 SHALL have parameter FAN_IN, default 4, number of quantised inputs per neuron.
REQ-002 SHALL have parameter IN_BITS, default 2, bits per input.
REQ-003 SHALL have parameter OUT_BITS, default 2, output activation width.
REQ-004 SHALL derive AW = FAN_IN*IN_BITS as the table address width; table depth 2^AW.
REQ-005 SHALL have port clk  in  1  sole clock, rising edge.
REQ-006 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-007 SHALL have port in_data  in  AW  packed inputs; input i at bits [i*IN_BITS +: IN_BITS].
REQ-008 SHALL have port in_valid  in  1  in_data valid.
REQ-009 SHALL have port in_ready  out  1  block accepts in_data this cycle.
REQ-010 SHALL have port out_data  out  OUT_BITS  looked-up activation.
REQ-011 SHALL have port out_valid  out  1  out_data valid.
REQ-012 SHALL have port out_ready  in  1  downstream accepts out_data.
REQ-013 SHALL have port cfg_we  in  1  table write strobe.
REQ-014 SHALL have port cfg_addr  in  AW  table write address.
REQ-015 SHALL have port cfg_data  in  OUT_BITS  table write data.
REQ-016 SHALL have port out_count  out  16  count of completed output handshakes.

Function
REQ-017 SHALL hold a 2^AW x OUT_BITS truth table in distributed RAM; address = in_data unmodified.
REQ-018 SHALL write cfg_data to table[cfg_addr] at the rising edge where cfg_we=1; writes are accepted every cycle, independent of the handshake.
REQ-019 SHALL implement two stages: S1 registers the accepted address; S2 registers table[S1 address].
REQ-020 SHALL accept an input when in_valid & in_ready are both 1 at a rising edge.
REQ-021 SHALL advance S2 when S2 is empty or out_ready=1; advance S1 into S2 when S1 holds data and S2 advances.
REQ-022 SHALL drive in_ready = !S1_valid | S1_advances (combinational path from out_ready permitted).
REQ-023 SHALL give latency exactly 2 cycles from input handshake to out_valid=1 when out_ready is held 1; throughput 1 per cycle.
REQ-024 SHALL hold out_data and out_valid stable while out_valid=1 and out_ready=0.
REQ-025 SHALL never drop, duplicate or reorder transactions; at most 2 in flight.
REQ-026 SHALL, when a table write and an S1->S2 read hit the same address at one edge, capture the OLD table value into S2 (read-before-write).
REQ-027 SHALL use the table contents in place at the S1->S2 edge, so a write landing while a transaction sits in S1 is seen by that transaction.
REQ-028 SHALL increment out_count on each out_valid & out_ready edge, wrapping 0xFFFF -> 0x0000.
REQ-029 SHALL not act on in_data when in_valid=0 (stage-valid flags unchanged by data value).

Reset
REQ-030 SHALL, on rst=1 at a rising edge, clear S1/S2 valid flags, S1/S2 data registers and out_count to 0; out_valid=0, out_data=0 and in_ready=1 in the cycle after.
REQ-031 SHALL not modify table contents on reset; table initialises to all-zero at configuration.
REQ-032 SHALL discard in-flight transactions on reset mid-operation; no output handshake occurs for them.
REQ-033 SHALL give rst priority over a simultaneous input handshake or cfg_we (neither takes effect that edge).

Verification
REQ-034 Load table[0x00]=2'b10, table[0x40]=2'b01; out_ready=1; send 0x00 then 0x40 back-to-back -> out_valid at cycles +2, +3 with 2'b10, 2'b01; out_count=2.
REQ-035 out_ready=0, offer 3 inputs continuously -> first 2 accepted, in_ready=0 thereafter, out_data frozen on the first result; raise out_ready -> 3 outputs in order, no gaps.
REQ-036 table[0x10]=2'b11; input 0x10 in S1 while cfg_we writes 0x10 <- 2'b00 on the S1->S2 edge -> output 2'b11; next input 0x10 -> 2'b00.
REQ-037 Assert rst with 2 transactions in flight -> out_valid=0, out_count=0 next cycle, no stale output later; table entries retain loaded values.
REQ-038 Preload via 65535 handshakes, one more -> out_count wraps 0xFFFF -> 0x0000.
REQ-039 Parameter FAN_IN=6, IN_BITS=3, OUT_BITS=4: random table and random stream with random out_ready vs reference model -> all outputs match, in order.

Source files
------------

// File: rtl/lut_neuron_pipe.sv
// Two-stage LUT neuron: S1 registers the packed input address, S2 registers the
// table lookup. The table is rewritable at any time through the cfg port.
module lut_neuron_pipe #(
  parameter int unsigned FAN_IN   = 4,
  parameter int unsigned IN_BITS  = 2,
  parameter int unsigned OUT_BITS = 2,
  localparam int unsigned AW      = FAN_IN * IN_BITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [AW-1:0]       in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [OUT_BITS-1:0] out_data,
  output logic                out_valid,
  input  logic                out_ready,
  input  logic                cfg_we,
  input  logic [AW-1:0]       cfg_addr,
  input  logic [OUT_BITS-1:0] cfg_data,
  output logic [15:0]         out_count
);

  localparam int unsigned Depth = 1 << AW;

  logic [OUT_BITS-1:0] lut_mem [Depth];

  logic                s1_valid_q;
  logic [AW-1:0]       s1_addr_q;
  logic                s2_valid_q;
  logic [OUT_BITS-1:0] s2_data_q;
  logic [15:0]         count_q;

  logic s2_adv;
  logic s1_adv;
  logic accept;

  always_comb begin
    s2_adv = !s2_valid_q || out_ready;
    s1_adv = s1_valid_q && s2_adv;
    accept = in_valid && in_ready;
  end

  assign in_ready  = !s1_valid_q || s1_adv;
  assign out_valid = s2_valid_q;
  assign out_data  = s2_data_q;
  assign out_count = count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_addr_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      count_q    <= '0;
    end else begin
      if (accept) begin
        s1_valid_q <= 1'b1;
        s1_addr_q  <= in_data;
      end else if (s1_adv) begin
        s1_valid_q <= 1'b0;
      end
      // Nonblocking read of lut_mem sees the pre-write value on a same-address write.
      if (s2_adv) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          s2_data_q <= lut_mem[s1_addr_q];
        end
      end
      if (s2_valid_q && out_ready) begin
        count_q <= count_q + 16'd1;
      end
    end
  end

  // Table has no reset; rst only blocks a coincident write.
  always_ff @(posedge clk) begin
    if (!rst && cfg_we) begin
      lut_mem[cfg_addr] <= cfg_data;
    end
  end

endmodule

// File: tb/tb_lut_neuron_pipe.sv
// Directed checks on the default neuron plus a randomized stream on a wide
// (6x3-bit in, 4-bit out) instance against a queue-based reference model.
module tb_lut_neuron_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Default instance
  logic [7:0]  a_in_data  = '0;
  logic        a_in_valid = 1'b0;
  logic        a_in_ready;
  logic [1:0]  a_out_data;
  logic        a_out_valid;
  logic        a_out_ready = 1'b0;
  logic        a_cfg_we    = 1'b0;
  logic [7:0]  a_cfg_addr  = '0;
  logic [1:0]  a_cfg_data  = '0;
  logic [15:0] a_out_count;

  // Wide instance
  logic [17:0] b_in_data  = '0;
  logic        b_in_valid = 1'b0;
  logic        b_in_ready;
  logic [3:0]  b_out_data;
  logic        b_out_valid;
  logic        b_out_ready = 1'b0;
  logic        b_cfg_we    = 1'b0;
  logic [17:0] b_cfg_addr  = '0;
  logic [3:0]  b_cfg_data  = '0;
  logic [15:0] b_out_count;

  lut_neuron_pipe u_dut_a (
    .clk       (clk),
    .rst       (rst),
    .in_data   (a_in_data),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .out_data  (a_out_data),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready),
    .cfg_we    (a_cfg_we),
    .cfg_addr  (a_cfg_addr),
    .cfg_data  (a_cfg_data),
    .out_count (a_out_count)
  );

  lut_neuron_pipe #(
    .FAN_IN   (6),
    .IN_BITS  (3),
    .OUT_BITS (4)
  ) u_dut_b (
    .clk       (clk),
    .rst       (rst),
    .in_data   (b_in_data),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .out_data  (b_out_data),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .cfg_we    (b_cfg_we),
    .cfg_addr  (b_cfg_addr),
    .cfg_data  (b_cfg_data),
    .out_count (b_out_count)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_write(input logic [7:0] addr, input logic [1:0] data);
    a_cfg_we   = 1'b1;
    a_cfg_addr = addr;
    a_cfg_data = data;
    tick();
    a_cfg_we = 1'b0;
  endtask

  // Reference model for the wide instance: table shadow + in-flight queue
  // holding the expected result and the edge index at which it was accepted.
  logic [17:0] pool  [32];
  logic [3:0]  b_tab [32];
  logic [3:0]  exp_q [$];
  int          acc_q [$];
  int          edge_n = 0;

  task automatic b_step(input logic v, input int idx, input logic r);
    logic exp_rdy, exp_ov, hs_in, hs_out;
    b_in_valid  = v;
    b_in_data   = v ? pool[idx] : 18'($urandom);
    b_out_ready = r;
    #1;
    exp_rdy = (exp_q.size() < 2) || r;
    exp_ov  = (exp_q.size() > 0) && (acc_q[0] < edge_n);
    check("b_in_ready", 32'(b_in_ready), 32'(exp_rdy));
    check("b_out_valid", 32'(b_out_valid), 32'(exp_ov));
    if (exp_ov) check("b_out_data", 32'(b_out_data), 32'(exp_q[0]));
    hs_in  = v && exp_rdy;
    hs_out = exp_ov && r;
    @(posedge clk);
    edge_n++;
    if (hs_out) begin
      void'(exp_q.pop_front());
      void'(acc_q.pop_front());
    end
    if (hs_in) begin
      exp_q.push_back(b_tab[idx]);
      acc_q.push_back(edge_n);
    end
    #1;
  endtask

  logic [15:0] exp_cnt;

  initial begin
    // Reset state
    tick();
    rst = 1'b0;
    check("rst_out_valid", 32'(a_out_valid), 32'd0);
    check("rst_out_data", 32'(a_out_data), 32'd0);
    check("rst_in_ready", 32'(a_in_ready), 32'd1);
    check("rst_out_count", 32'(a_out_count), 32'd0);
    check("rst_b_out_valid", 32'(b_out_valid), 32'd0);

    // Back-to-back lookups, latency 2
    a_write(8'h00, 2'b10);
    a_write(8'h40, 2'b01);
    a_write(8'h10, 2'b11);
    a_out_ready = 1'b1;
    a_in_valid  = 1'b1;
    a_in_data   = 8'h00;
    check("b2b_rdy0", 32'(a_in_ready), 32'd1);
    tick();
    a_in_data = 8'h40;
    check("b2b_rdy1", 32'(a_in_ready), 32'd1);
    check("b2b_ov_c1", 32'(a_out_valid), 32'd0);
    tick();
    a_in_valid = 1'b0;
    check("b2b_ov_c2", 32'(a_out_valid), 32'd1);
    check("b2b_d_c2", 32'(a_out_data), 32'h2);
    tick();
    check("b2b_ov_c3", 32'(a_out_valid), 32'd1);
    check("b2b_d_c3", 32'(a_out_data), 32'h1);
    tick();
    check("b2b_ov_c4", 32'(a_out_valid), 32'd0);
    check("b2b_count", 32'(a_out_count), 32'd2);

    // Backpressure: two accepted, third held off, output frozen
    a_out_ready = 1'b0;
    a_in_valid  = 1'b1;
    a_in_data   = 8'h00;
    tick();
    a_in_data = 8'h40;
    check("bp_rdy1", 32'(a_in_ready), 32'd1);
    tick();
    a_in_data = 8'h10;
    for (int i = 0; i < 3; i++) begin
      check("bp_rdy_stall", 32'(a_in_ready), 32'd0);
      check("bp_ov_stall", 32'(a_out_valid), 32'd1);
      check("bp_d_stall", 32'(a_out_data), 32'h2);
      tick();
    end
    a_out_ready = 1'b1;
    #1;
    check("bp_rdy_release", 32'(a_in_ready), 32'd1);
    tick();
    a_in_valid = 1'b0;
    check("bp_ov_o2", 32'(a_out_valid), 32'd1);
    check("bp_d_o2", 32'(a_out_data), 32'h1);
    tick();
    check("bp_ov_o3", 32'(a_out_valid), 32'd1);
    check("bp_d_o3", 32'(a_out_data), 32'h3);
    tick();
    check("bp_ov_end", 32'(a_out_valid), 32'd0);
    check("bp_count", 32'(a_out_count), 32'd5);

    // Write hitting the S1->S2 read of the same address
    a_in_valid = 1'b1;
    a_in_data  = 8'h10;
    tick();
    a_in_valid = 1'b0;
    a_cfg_we   = 1'b1;
    a_cfg_addr = 8'h10;
    a_cfg_data = 2'b00;
    tick();
    a_cfg_we = 1'b0;
    check("rbw_ov", 32'(a_out_valid), 32'd1);
    check("rbw_old", 32'(a_out_data), 32'h3);
    tick();
    a_in_valid = 1'b1;
    tick();
    a_in_valid = 1'b0;
    tick();
    check("rbw_new", 32'(a_out_data), 32'h0);
    tick();

    // Reset with two in flight, coincident handshake and write ignored
    a_out_ready = 1'b0;
    a_in_valid  = 1'b1;
    a_in_data   = 8'h00;
    tick();
    a_in_data = 8'h40;
    tick();
    rst         = 1'b1;
    a_out_ready = 1'b1;
    a_cfg_we    = 1'b1;
    a_cfg_addr  = 8'h00;
    a_cfg_data  = 2'b11;
    tick();
    rst        = 1'b0;
    a_in_valid = 1'b0;
    a_cfg_we   = 1'b0;
    check("mrst_ov", 32'(a_out_valid), 32'd0);
    check("mrst_od", 32'(a_out_data), 32'd0);
    check("mrst_count", 32'(a_out_count), 32'd0);
    check("mrst_rdy", 32'(a_in_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mrst_no_stale", 32'(a_out_valid), 32'd0);
    end
    a_in_valid = 1'b1;
    a_in_data  = 8'h00;
    tick();
    a_in_data = 8'h40;
    tick();
    a_in_valid = 1'b0;
    check("mrst_tab0", 32'(a_out_data), 32'h2);
    tick();
    check("mrst_tab40", 32'(a_out_data), 32'h1);
    tick();
    check("mrst_count2", 32'(a_out_count), 32'd2);

    // Randomized stream on the wide instance
    for (int i = 0; i < 32; i++) begin
      pool[i]    = {5'(i), 13'($urandom)};
      b_tab[i]   = 4'($urandom);
      b_cfg_we   = 1'b1;
      b_cfg_addr = pool[i];
      b_cfg_data = b_tab[i];
      tick();
    end
    b_cfg_we = 1'b0;
    edge_n   = 0;
    for (int i = 0; i < 1500; i++) begin
      b_step(($urandom % 4) != 0, int'($urandom % 32), ($urandom % 3) != 0);
    end
    for (int i = 0; i < 4; i++) begin
      b_step(1'b0, 0, 1'b1);
    end
    check("b_drain", 32'(exp_q.size()), 32'd0);

    // Counter wrap: stream until 0xFFFF, then one more handshake
    exp_cnt     = 16'd2;
    a_in_valid  = 1'b1;
    a_in_data   = 8'h00;
    a_out_ready = 1'b1;
    for (int i = 0; i < 70000 && exp_cnt != 16'hFFFF; i++) begin
      if (a_out_valid) exp_cnt++;
      tick();
    end
    check("wrap_reach", 32'(a_out_count), 32'hFFFF);
    check("wrap_model", 32'(exp_cnt), 32'hFFFF);
    a_in_valid  = 1'b0;
    a_out_ready = 1'b0;
    #1;
    check("wrap_ov", 32'(a_out_valid), 32'd1);
    tick();
    check("wrap_hold", 32'(a_out_count), 32'hFFFF);
    a_out_ready = 1'b1;
    tick();
    check("wrap_zero", 32'(a_out_count), 32'h0000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
